pe_nic: RTL

Network interface controller between a processing element and the PE port of a mesh router. Exposes a 4-word register map to the PE, holds one injection packet in an output channel buffer, and injects it into the router with the router's send/ready handshake only in the clock phase whose polarity matches the packet's virtual-channel bit. Packets ejected by the router are captured in a one-entry input channel buffer and read by the PE through the same register map.

---
 rtl/pe_nic.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pe_nic.sv
// pe_nic: network interface between a processing element and the PE port of a
// mesh router. One-entry output channel buffer (PE -> router) injected only in
// the router phase whose polarity matches the packet VC bit, one-entry input
// channel buffer (router -> PE), and a 4-word PE register map:
//   00 input data   01 input status   10 output data   11 output status
// Optional feature: define NIC_PKT_CNT_EN to add 16-bit wrapping tx/rx packet
// counters reported in bits [31:16] of the status words.
module pe_nic #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_so,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_ro,
  input  logic                  net_si,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_ri,
  input  logic                  net_polarity
);

  localparam logic [1:0] ADDR_IN_DATA   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT   = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT  = 2'b11;

  logic [DATA_WIDTH-1:0] in_buf_q,  in_buf_d;
  logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
  logic [DATA_WIDTH-1:0] d_out_q,   d_out_d;
  logic                  in_full_q,  in_full_d;
  logic                  out_full_q, out_full_d;
  logic                  ovf_q,      ovf_d;

  logic                  pe_wr;
  logic                  pe_rd;
  logic                  out_wr;
  logic                  out_accept;
  logic                  capture;
  logic                  inject;
  logic [DATA_WIDTH-1:0] in_status;
  logic [DATA_WIDTH-1:0] out_status;

`ifdef NIC_PKT_CNT_EN
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
`endif

  // Handshake decode: inject only when the router is ready and its phase
  // matches the VC bit of the buffered packet; accept only when empty.
  always_comb begin
    inject     = out_full_q & net_ro & (out_buf_q[DATA_WIDTH-1] == net_polarity);
    capture    = net_si & ~in_full_q;
    pe_wr      = nicEn & nicWrEn;
    pe_rd      = nicEn & ~nicWrEn;
    out_wr     = pe_wr & (addr == ADDR_OUT_DATA);
    // A packet leaving in this cycle frees the buffer for a same-cycle write.
    out_accept = out_wr & (~out_full_q | inject);
  end

  assign net_so = inject;
  assign net_do = out_buf_q;
  assign net_ri = ~in_full_q;
  assign d_out  = d_out_q;

  // Status words: flags in the low bits, optional packet counts in [31:16].
  always_comb begin
    in_status     = '0;
    out_status    = '0;
    in_status[0]  = in_full_q;
    out_status[0] = out_full_q;
    out_status[1] = ovf_q;
`ifdef NIC_PKT_CNT_EN
    in_status[31:16]  = rx_cnt_q;
    out_status[31:16] = tx_cnt_q;
`endif
  end

  // Next-state logic for both channel buffers, overflow flag and read data.
  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    ovf_d      = ovf_q;
    d_out_d    = d_out_q;

    // Output channel: a transfer empties the buffer unless refilled this cycle.
    if (inject) begin
      out_full_d = 1'b0;
    end
    if (out_accept) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end else if (out_wr) begin
      ovf_d = 1'b1;
    end

    // Input channel: router arrivals only land in an empty buffer, so a
    // clearing read and a capture never coincide.
    if (capture) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end

    if (pe_rd) begin
      unique case (addr)
        ADDR_IN_DATA: begin
          d_out_d = in_buf_q;
          if (in_full_q) begin
            in_full_d = 1'b0;
          end
        end
        ADDR_IN_STAT:  d_out_d = in_status;
        ADDR_OUT_DATA: d_out_d = '0;
        ADDR_OUT_STAT: begin
          d_out_d = out_status;
          ovf_d   = 1'b0;
        end
        default:       d_out_d = d_out_q;
      endcase
    end
  end

  // State registers; reset discards both buffers and any pending read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
      ovf_q      <= 1'b0;
      d_out_q    <= '0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
      ovf_q      <= ovf_d;
      d_out_q    <= d_out_d;
    end
  end

`ifdef NIC_PKT_CNT_EN
  // Packet counters advance on each completed handshake and wrap naturally.
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    if (inject) begin
      tx_cnt_d = tx_cnt_q + 16'd1;
    end
    if (capture) begin
      rx_cnt_d = rx_cnt_q + 16'd1;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end
`endif

endmodule
